// File: rtl/wb_pkg.sv
// Shared Wishbone B4 classic types, default widths and the response priority encoder.
package wb_pkg;

  localparam int WB_ADR_WIDTH = 16;
  localparam int WB_DAT_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_RSP_NONE = 2'd0,
    WB_RSP_ACK  = 2'd1,
    WB_RSP_ERR  = 2'd2,
    WB_RSP_RTY  = 2'd3
  } wb_rsp_e;

  // A misbehaving device may raise several terminators at once; err beats rty beats ack.
  function automatic wb_rsp_e wb_prio_rsp(input logic ack, input logic err, input logic rty);
    if (err) return WB_RSP_ERR;
    if (rty) return WB_RSP_RTY;
    if (ack) return WB_RSP_ACK;
    return WB_RSP_NONE;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping, one-hot out.
module wb_rr_pick #(
  parameter int NUM_CTRL = 2
) (
  input  logic [NUM_CTRL-1:0]         req_i,
  input  logic [$clog2(NUM_CTRL)-1:0] ptr_i,
  output logic [NUM_CTRL-1:0]         gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_CTRL) idx = idx - NUM_CTRL;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_classic_arbiter.sv
// N-controller to 1-device Wishbone B4 classic arbiter: round-robin, cycle locking,
// and a watchdog that terminates hung beats with err.
module wishbone_classic_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_CTRL  = 2,
  parameter int ADR_WIDTH = WB_ADR_WIDTH,
  parameter int DAT_WIDTH = WB_DAT_WIDTH,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_CTRL-1:0]           c_cyc_i,
  input  logic [NUM_CTRL-1:0]           c_stb_i,
  input  logic [NUM_CTRL-1:0]           c_we_i,
  input  logic [NUM_CTRL*ADR_WIDTH-1:0] c_adr_i,
  input  logic [NUM_CTRL*SEL_WIDTH-1:0] c_sel_i,
  input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
  output logic [NUM_CTRL-1:0]           c_ack_o,
  output logic [NUM_CTRL-1:0]           c_err_o,
  output logic [NUM_CTRL-1:0]           c_rty_o,
  output logic [DAT_WIDTH-1:0]          c_dat_o,
  output logic                          d_cyc_o,
  output logic                          d_stb_o,
  output logic                          d_we_o,
  output logic [ADR_WIDTH-1:0]          d_adr_o,
  output logic [SEL_WIDTH-1:0]          d_sel_o,
  output logic [DAT_WIDTH-1:0]          d_dat_o,
  input  logic                          d_ack_i,
  input  logic                          d_err_i,
  input  logic                          d_rty_i,
  input  logic [DAT_WIDTH-1:0]          d_dat_i,
  output logic [NUM_CTRL-1:0]           grant_o
);

  localparam int PW = $clog2(NUM_CTRL);

  // Handshake: a beat is offered while cyc and stb are both high and completes in the
  // cycle the device returns ack, err or rty; stb and payload stay stable until then.

  logic [NUM_CTRL-1:0] g_q, g_nxt, win, own_cyc;
  logic [PW-1:0]       ptr_q, ptr_nxt;
  logic                arb_en, stb_raw, to_q;
  logic                fwd_ack, fwd_err, fwd_rty;
  wb_rsp_e             rsp;

  assign own_cyc = g_q & c_cyc_i;
  assign arb_en  = ~|own_cyc;

  wb_rr_pick #(.NUM_CTRL(NUM_CTRL)) u_pick (
    .req_i (c_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  always_comb begin
    g_nxt   = g_q;
    ptr_nxt = ptr_q;
    if (arb_en) begin
      g_nxt = win;
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (win[k]) ptr_nxt = (k == NUM_CTRL - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      g_q   <= '0;
      ptr_q <= '0;
    end else begin
      g_q   <= g_nxt;
      ptr_q <= ptr_nxt;
    end
  end

  assign grant_o = g_q;

  // Device side follows the registered owner, so a fresh owner drives one cycle after it wins.
  assign stb_raw = |(own_cyc & c_stb_i);
  assign d_cyc_o = |own_cyc;
  assign d_stb_o = stb_raw & ~to_q;

  always_comb begin
    d_we_o  = 1'b0;
    d_adr_o = '0;
    d_sel_o = '0;
    d_dat_o = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (g_q[k]) begin
        d_we_o  = c_we_i[k];
        d_adr_o = c_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
        d_sel_o = c_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
        d_dat_o = c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign rsp     = wb_prio_rsp(d_ack_i, d_err_i, d_rty_i);
  assign fwd_ack = d_stb_o && (rsp == WB_RSP_ACK);
  assign fwd_err = d_stb_o && (rsp == WB_RSP_ERR);
  assign fwd_rty = d_stb_o && (rsp == WB_RSP_RTY);

  assign c_ack_o = g_q & {NUM_CTRL{fwd_ack}};
  assign c_err_o = g_q & {NUM_CTRL{fwd_err | to_q}};
  assign c_rty_o = g_q & {NUM_CTRL{fwd_rty}};
  assign c_dat_o = d_dat_i;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q;
      logic          any_rsp;

      assign any_rsp = d_ack_i | d_err_i | d_rty_i;

      // The flag is raised on the last silent wait cycle so the err lands on the next one;
      // a response in that last cycle clears the count and suppresses the err.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
          to_q  <= 1'b0;
        end else begin
          to_q <= 1'b0;
          if (!d_stb_o || any_rsp || (g_nxt != g_q)) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            cnt_q <= '0;
            to_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end else begin : g_no_wdog
      assign to_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wishbone_classic_arbiter.sv
// Directed bench for wishbone_classic_arbiter (2 controllers, TIMEOUT=4).
module tb_wishbone_classic_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      c_cyc, c_stb, c_we;
  logic [N*AW-1:0]   c_adr;
  logic [N*SW-1:0]   c_sel;
  logic [N*DW-1:0]   c_dat;
  logic [N-1:0]      c_ack, c_err, c_rty;
  logic [DW-1:0]     c_rdat;
  logic              d_cyc, d_stb, d_we;
  logic [AW-1:0]     d_adr;
  logic [SW-1:0]     d_sel;
  logic [DW-1:0]     d_wdat;
  logic              d_ack, d_err, d_rty;
  logic [DW-1:0]     d_rdat;
  logic [N-1:0]      grant;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  wishbone_classic_arbiter #(
    .NUM_CTRL (N),
    .ADR_WIDTH(AW),
    .DAT_WIDTH(DW),
    .TIMEOUT  (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .c_cyc_i(c_cyc),
    .c_stb_i(c_stb),
    .c_we_i (c_we),
    .c_adr_i(c_adr),
    .c_sel_i(c_sel),
    .c_dat_i(c_dat),
    .c_ack_o(c_ack),
    .c_err_o(c_err),
    .c_rty_o(c_rty),
    .c_dat_o(c_rdat),
    .d_cyc_o(d_cyc),
    .d_stb_o(d_stb),
    .d_we_o (d_we),
    .d_adr_o(d_adr),
    .d_sel_o(d_sel),
    .d_dat_o(d_wdat),
    .d_ack_i(d_ack),
    .d_err_i(d_err),
    .d_rty_i(d_rty),
    .d_dat_i(d_rdat),
    .grant_o(grant)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb,
                       input logic ack, input logic err, input logic rty);
    c_cyc = cyc;
    c_stb = stb;
    d_ack = ack;
    d_err = err;
    d_rty = rty;
  endtask

  logic [1:0] rr_cyc [10] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rr_gnt [10] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
  logic [1:0] rr_ack [10] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};

  initial begin
    rst_n  = 1'b0;
    c_we   = 2'b10;
    c_adr  = {16'h0040, 16'h1111};
    c_sel  = {4'hF, 4'h3};
    c_dat  = {32'hDEADBEEF, 32'h0BADF00D};
    d_rdat = '0;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // reset state
    step(); step();
    check("rst_grant", grant, 0);
    check("rst_d_cyc", d_cyc, 0);
    check("rst_d_stb", d_stb, 0);
    rst_n = 1'b1;
    step();

    // single request from controller 1, async ack three cycles after the request
    drive(2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
    #1;
    check("sr_grant_lat", grant, 2'b00);
    check("sr_d_cyc_lat", d_cyc, 0);
    check("sr_d_adr_idle", d_adr, 0);
    step(); #1;
    check("sr_grant", grant, 2'b10);
    check("sr_d_adr", d_adr, 16'h0040);
    check("sr_d_we", d_we, 1);
    check("sr_d_sel", d_sel, 4'hF);
    check("sr_d_dat", d_wdat, 32'hDEADBEEF);
    check("sr_d_stb", d_stb, 1);
    check("sr_ack_c1", c_ack, 2'b00);
    step(); #1;
    check("sr_ack_c2", c_ack, 2'b00);
    step();
    drive(2'b10, 2'b10, 1'b1, 1'b0, 1'b0);
    #1;
    check("sr_ack", c_ack, 2'b10);
    step();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    check("sr_ack_done", c_ack, 2'b00);
    check("sr_d_cyc_drop", d_cyc, 0);
    check("sr_grant_hold", grant, 2'b10);
    step(); #1;
    check("sr_grant_idle", grant, 2'b00);

    // round robin, one beat per tenure, device always acking
    foreach (rr_gnt[i]) exp_q.push_back(rr_gnt[i]);
    for (int i = 0; i < 10; i++) begin
      step();
      drive(rr_cyc[i], rr_cyc[i], 1'b1, 1'b0, 1'b0);
      #1;
      check($sformatf("rr_grant_%0d", i), grant, exp_q.pop_front());
      check($sformatf("rr_ack_%0d", i), c_ack, rr_ack[i]);
    end
    step();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    check("rr_grant_idle", grant, 2'b00);

    // locking: controller 0 keeps the bus across three beats while controller 1 waits
    step(); drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0); #1;
    check("lk_grant_0", grant, 2'b00);
    step(); drive(2'b11, 2'b11, 1'b1, 1'b0, 1'b0); #1;
    check("lk_grant_1", grant, 2'b01);
    check("lk_ack_1", c_ack, 2'b01);
    step(); drive(2'b11, 2'b10, 1'b0, 1'b0, 1'b0); #1;
    check("lk_grant_2", grant, 2'b01);
    check("lk_ack_2", c_ack, 2'b00);
    step(); drive(2'b11, 2'b11, 1'b1, 1'b0, 1'b0); #1;
    check("lk_grant_3", grant, 2'b01);
    check("lk_ack_3", c_ack, 2'b01);
    step(); drive(2'b11, 2'b11, 1'b1, 1'b0, 1'b0); #1;
    check("lk_grant_4", grant, 2'b01);
    check("lk_ack_4", c_ack, 2'b01);
    step(); drive(2'b10, 2'b10, 1'b0, 1'b0, 1'b0); #1;
    check("lk_grant_5", grant, 2'b01);
    check("lk_d_cyc_5", d_cyc, 0);
    step(); #1;
    check("lk_grant_6", grant, 2'b10);
    check("lk_d_cyc_6", d_cyc, 1);
    step(); drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(); #1;
    check("lk_grant_idle", grant, 2'b00);

    // watchdog: silent device, err on the fifth strobe cycle
    step(); drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      check($sformatf("to_err_wait_%0d", i), c_err, 2'b00);
      check($sformatf("to_stb_wait_%0d", i), d_stb, 1);
    end
    step(); #1;
    check("to_err", c_err, 2'b01);
    check("to_stb_forced", d_stb, 0);
    check("to_grant_kept", grant, 2'b01);
    check("to_d_cyc", d_cyc, 1);
    for (int i = 1; i <= 3; i++) begin
      step(); #1;
      check($sformatf("to_rearm_%0d", i), c_err, 2'b00);
    end
    // device answers on the last wait cycle: ack wins, no forced err afterwards
    step();
    d_rdat = 32'h12345678;
    drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    #1;
    check("col_ack", c_ack, 2'b01);
    check("col_no_err", c_err, 2'b00);
    check("col_rdat", c_rdat, 32'h12345678);
    step(); drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0); #1;
    check("col_err_after", c_err, 2'b00);
    check("col_stb_after", d_stb, 1);
    step(); step();
    step(); drive(2'b01, 2'b01, 1'b1, 1'b1, 1'b0); #1;
    check("prio_err", c_err, 2'b01);
    check("prio_err_noack", c_ack, 2'b00);
    step(); drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b1); #1;
    check("prio_rty", c_rty, 2'b01);
    check("prio_rty_noack", c_ack, 2'b00);
    check("prio_rty_noerr", c_err, 2'b00);
    step(); drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(); #1;
    check("to_grant_idle", grant, 2'b00);

    // reset while controller 0 owns the bus, then pointer must restart at 0
    step(); drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    step(); drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0); #1;
    check("mr_grant_pre", grant, 2'b01);
    check("mr_d_cyc_pre", d_cyc, 1);
    check("mr_ack_pre", c_ack, 2'b01);
    #1;
    rst_n = 1'b0;
    drive(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    #1;
    check("mr_grant_async", grant, 2'b00);
    check("mr_d_cyc_async", d_cyc, 0);
    check("mr_d_stb_async", d_stb, 0);
    check("mr_ack_async", c_ack, 2'b00);
    step();
    rst_n = 1'b1;
    #1;
    check("mr_grant_rel", grant, 2'b00);
    step(); #1;
    check("mr_ptr_zero", grant, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wishbone_classic_arbiter.md
Name: wishbone_classic_arbiter

Overview:
Parametrised N-controller to 1-device Wishbone B4 classic shared-bus arbiter. It is the next-generation bus primitive for the common library.
- Adds configurable address, data and byte-select widths.
- Adds round-robin arbitration with cycle locking.
- Adds a bus-timeout watchdog that terminates hung beats with err.
- Sits between CPU/DMA controllers and a single peripheral or interconnect port.

Parameters:
NUM_CTRL, 2, number of controller ports (>=2)
ADR_WIDTH, 16, address width
DAT_WIDTH, 32, data width (multiple of 8)
SEL_WIDTH, DAT_WIDTH/8, byte-select width (derived; not overridden)
TIMEOUT, 255, wait-state cycles before forced err; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
c_cyc_i  in  NUM_CTRL  per-controller cyc
c_stb_i  in  NUM_CTRL  per-controller stb
c_we_i  in  NUM_CTRL  per-controller we
c_adr_i  in  NUM_CTRL*ADR_WIDTH  packed addresses, controller k at slice k
c_sel_i  in  NUM_CTRL*SEL_WIDTH  packed byte selects
c_dat_i  in  NUM_CTRL*DAT_WIDTH  packed write data
c_ack_o  out  NUM_CTRL  per-controller ack
c_err_o  out  NUM_CTRL  per-controller err
c_rty_o  out  NUM_CTRL  per-controller rty
c_dat_o  out  DAT_WIDTH  read data, broadcast to all controllers
d_cyc_o  out  1  device cyc
d_stb_o  out  1  device stb
d_we_o  out  1  device we
d_adr_o  out  ADR_WIDTH  device address
d_sel_o  out  SEL_WIDTH  device byte select
d_dat_o  out  DAT_WIDTH  device write data
d_ack_i  in  1  device ack
d_err_i  in  1  device err
d_rty_i  in  1  device rty
d_dat_i  in  DAT_WIDTH  device read data
grant_o  out  NUM_CTRL  one-hot registered grant; all-zero when idle

Behaviour:
- Single clock clk_i; rst_ni is asynchronous, active-low.
- Reset:
  - grant_o=0 and round-robin pointer=0.
  - Timeout counter=0 and timeout-err flag=0.
  - All d_* control outputs and all c_ack/err/rty_o are 0 while rst_ni is low, including mid-cycle.
- State: registered grant vector g. Idle when g==0; owner k when g[k]=1. Never more than one bit set.
- Arbitration:
  - Evaluated when idle, or when the owner's c_cyc_i==0.
  - Winner is the first requesting c_cyc_i searching from pointer upward, wrapping at NUM_CTRL-1 to 0.
  - Result is registered, so grant latency is 1 cycle from the c_cyc_i rise.
  - Pointer becomes winner+1 mod NUM_CTRL on each new grant.
  - No requesters: g goes to 0.
- Locking: the owner keeps the grant for as long as its c_cyc_i stays high, across any number of beats. No preemption.
- Device drive, combinational from g:
  - d_cyc_o = |(g & c_cyc_i); d_stb_o = |(g & c_cyc_i & c_stb_i).
  - d_we/adr/sel/dat_o come from the owner's slice; all zero when idle.
- Response routing, combinational:
  - c_ack_o[k] = g[k] & d_stb_o & d_ack_i; err and rty are routed the same way.
  - Async (same-cycle) acks pass through with zero added latency.
  - Non-owners always see 0.
  - c_dat_o = d_dat_i at all times.
- Handover: when the owner drops c_cyc_i, d_cyc_o falls that cycle and the new owner drives from the next cycle. No dead cycle beyond the 1-cycle grant latency.
- Watchdog (TIMEOUT>0):
  - Counter increments each cycle d_stb_o=1 with no d_ack/err/rty.
  - Counter clears on any response, on d_stb_o=0, or on a grant change.
  - When the counter reaches TIMEOUT, the owner receives c_err_o=1 for exactly one cycle (registered flag) and the counter clears.
  - d_stb_o is forced 0 during that err cycle.
  - Counter width is $clog2(TIMEOUT+1).
- Simultaneous events:
  - Device response in the same cycle the counter hits TIMEOUT: the device response wins and no timeout err is raised.
  - Protocol violation where the device asserts more than one of ack/err/rty: forwarded with priority err > rty > ack, only one asserted.
  - Owner drops c_cyc_i while a response arrives: the response is gated off because d_stb_o=0.

Decomposition:
- Package wb_pkg:
  - Response enum {WB_RSP_NONE, WB_RSP_ACK, WB_RSP_ERR, WB_RSP_RTY}.
  - Helper function to priority-encode ack/err/rty.
  - Localparam defaults for ADR/DAT widths.
- Sub-module wb_rr_pick: combinational round-robin picker. Inputs are request vector and pointer; output is one-hot winner. Parametrised by NUM_CTRL.
- The arbiter instantiates one wb_rr_pick.

Test Plan:
- Reset mid-cycle: controller 0 granted with d_cyc_o=1, pull rst_ni low -> d_cyc_o and grant_o are 0 immediately, not at the next edge; after release, pointer=0.
- Single request:
  - Stimulus: c_cyc_i=2'b10 with stb, we=1, adr=16'h0040, dat=32'hDEADBEEF; device acks async 3 cycles later.
  - Response: grant_o=2'b10 one cycle after the request, and d_adr_o=16'h0040; c_ack_o=2'b10 for 1 cycle, c_ack_o[0] never set.
- Round-robin: both controllers hold c_cyc_i high, each dropping it after 1 beat -> grants alternate 01,10,01,10 with no controller granted twice in a row.
- Locking: controller 0 runs a 3-beat cycle (cyc held, stb pulsed) while controller 1 requests -> controller 1 is not granted until the cycle after c_cyc_i[0] falls.
- Timeout: TIMEOUT=4, device never responds -> c_err_o[owner]=1 exactly at the 5th stb cycle, d_stb_o=0 that cycle, grant retained.
- Collision: d_ack_i rises on the cycle the counter reaches TIMEOUT -> ack forwarded, no err; simultaneous d_err_i and d_ack_i -> only err forwarded.
